// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Store-side narrowing unit between the CPU memory stage and a word-organised
// data memory. It accepts a 32-bit register value with a byte address and a
// store size (SB/SH/SW). It places the addressed byte or halfword into its
// little-endian lane and writes the resulting word to memory.
//
// Default build: byte and halfword stores use a read-modify-write sequence
// (READ the containing word, merge, then WRITE).
// Optional build (`define SMU_BYTE_STROBE_EN): adds mem_be[3:0]. Sub-word
// stores skip READ. Their data is replicated across all lanes and the write
// is qualified by the byte mask.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while IDLE)
//   req_addr            byte address of the store
//   req_wdata           register data (low byte/half used for SB/SH)
//   req_size            00 byte, 01 half, 10 word, 11 reserved
//   resp_valid/err      one-cycle completion pulse, error qualifier
//   mem_addr            word address to memory (bits [1:0] zero)
//   mem_rd/rdata/rvalid read strobe held until rvalid, read data
//   mem_wr/wdata/wack   write strobe held until wack, merged write word
//   mem_be              byte write enables (SMU_BYTE_STROBE_EN only)
// -----------------------------------------------------------------------------
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
`ifdef SMU_BYTE_STROBE_EN
  output logic [3:0]        mem_be,
`endif
  input  logic              mem_wack
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e              state_q;
  logic                ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  // Request latches: only the low half of the data is ever needed after
  // acceptance, because a full-word store is written straight from req_wdata.
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [1:0]          size_q;
`ifdef SMU_BYTE_STROBE_EN
  logic [3:0]          mem_be_q;
`endif

  logic                err_d;
  logic [31:0]         merged_d;

  // Misaligned halfword/word or reserved size.
  function automatic logic is_err(input logic [1:0] a, input logic [1:0] sz);
    return (sz == 2'b11) ||
           ((sz == SZ_HALF) && a[0]) ||
           ((sz == SZ_WORD) && (a != 2'b00));
  endfunction

  // Little-endian lane insert of the narrowed store data into the old word.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [15:0] d,
                                        input logic [1:0]  lane,
                                        input logic [1:0]  sz);
    logic [31:0] r;
    r = old;
    if (sz == SZ_BYTE) r[{lane, 3'b000} +: 8]     = d[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

`ifdef SMU_BYTE_STROBE_EN
  function automatic logic [31:0] replicate(input logic [15:0] d, input logic [1:0] sz);
    return (sz == SZ_BYTE) ? {4{d[7:0]}} : {2{d}};
  endfunction

  function automatic logic [3:0] be_mask(input logic [1:0] lane, input logic [1:0] sz);
    if (sz == SZ_BYTE) return 4'b0001 << lane;
    return lane[1] ? 4'b1100 : 4'b0011;
  endfunction
`endif

  assign err_d    = is_err(req_addr[1:0], req_size);
  assign merged_d = merge(mem_rdata, wdata_q, addr_q[1:0], size_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
`ifdef SMU_BYTE_STROBE_EN
      mem_be_q     <= 4'b0000;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata[15:0];
            size_q  <= req_size;
            ready_q <= 1'b0;
            if (err_d) begin
              // Rejected requests never touch memory.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_size == SZ_WORD) begin
                state_q     <= S_WRITE;
                mem_wr_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
`ifdef SMU_BYTE_STROBE_EN
                mem_be_q    <= 4'b1111;
`endif
              end else begin
`ifdef SMU_BYTE_STROBE_EN
                state_q     <= S_WRITE;
                mem_wr_q    <= 1'b1;
                mem_wdata_q <= replicate(req_wdata[15:0], req_size);
                mem_be_q    <= be_mask(req_addr[1:0], req_size);
`else
                state_q     <= S_READ;
                mem_rd_q    <= 1'b1;
`endif
              end
            end
          end
        end
        S_READ: begin
          // A write ack seen here is ignored; only read data advances the RMW.
          if (mem_rvalid) begin
            state_q     <= S_WRITE;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merged_d;
          end
        end
        S_WRITE: begin
          if (mem_wack) begin
            state_q      <= S_RESP;
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
`ifdef SMU_BYTE_STROBE_EN
            mem_be_q     <= 4'b0000;
`endif
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          ready_q      <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
`ifdef SMU_BYTE_STROBE_EN
  assign mem_be     = mem_be_q;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_wack;
`ifdef SMU_BYTE_STROBE_EN
  logic [3:0]  mem_be;
`endif

  int n_chk;
  int n_err;

  // Reference memory image: 16 words covering byte addresses 0..63.
  logic [31:0] mem [16];

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
`ifdef SMU_BYTE_STROBE_EN
    .mem_be     (mem_be),
`endif
    .mem_wack   (mem_wack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One store transaction. rw/ww are memory wait cycles before rvalid/wack.
  task automatic do_store(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input int rw, input int ww);
    logic        err;
    logic [3:0]  widx;
    logic [31:0] old, mask, expw, expd, exp_addr;
    int          shamt, lat, rcnt, wcnt;
    bit          done, saw_rd, saw_wr, exp_rd;
`ifdef SMU_BYTE_STROBE_EN
    logic [3:0]  expbe;
`endif
    err      = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    widx     = a[5:2];
    old      = mem[widx];
    exp_addr = {a[31:2], 2'b00};
    case (sz)
      2'd0:    begin shamt = 8 * a[1:0];  mask = 32'h0000_00FF << shamt; end
      2'd1:    begin shamt = 16 * a[1];   mask = 32'h0000_FFFF << shamt; end
      default: begin shamt = 0;           mask = 32'hFFFF_FFFF;          end
    endcase
    expw = (old & ~mask) | ((wd << shamt) & mask);
`ifdef SMU_BYTE_STROBE_EN
    expd   = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
    expbe  = {|mask[31:24], |mask[23:16], |mask[15:8], |mask[7:0]};
    exp_rd = 1'b0;
    lat    = err ? 1 : 2 + ww;
`else
    expd   = expw;
    exp_rd = !err && (sz != 2'd2);
    lat    = err ? 1 : (sz == 2'd2) ? 2 + ww : 3 + rw + ww;
`endif
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_wdata = wd;
    @(posedge clk); #1;
    done = 0; saw_rd = 0; saw_wr = 0; rcnt = 0; wcnt = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      // Busy-state request inputs carry junk that must be ignored.
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_size   = 2'($urandom);
      req_wdata  = $urandom;
      mem_rvalid = 1'b0;
      mem_wack   = 1'b0;
      mem_rdata  = $urandom;
      chk("ready_busy", req_ready, 0);
      if (resp_valid) begin
        chk("resp_err", resp_err, err);
        chk("latency", c, lat);
`ifdef SMU_BYTE_STROBE_EN
        chk("be_resp", mem_be, 0);
`endif
        done = 1;
      end
      if (mem_rd) begin
        if (!saw_rd) chk("rd_addr", mem_addr, exp_addr);
        saw_rd = 1;
        if (rcnt == rw) begin mem_rvalid = 1'b1; mem_rdata = old; end
        else rcnt++;
        mem_wack = 1'($urandom_range(0, 1));
      end else if (mem_wr) begin
        saw_wr = 1;
        if (wcnt == ww) begin
          mem_wack = 1'b1;
          chk("wr_addr", mem_addr, exp_addr);
          chk("wr_data", mem_wdata, expd);
`ifdef SMU_BYTE_STROBE_EN
          chk("wr_be", mem_be, expbe);
`endif
          mem[widx] = expw;
        end else wcnt++;
        mem_rvalid = 1'($urandom_range(0, 1));
      end else begin
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_wack   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    if (!done) chk("timeout", 0, 1);
    chk("saw_rd", saw_rd, exp_rd);
    chk("saw_wr", saw_wr, !err);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_store(32'h10, 2'd2, 32'hDEADBEEF, 0, 0);
    mem[4] = 32'h11223344;
    do_store(32'h13, 2'd0, 32'hFFFF_FFA5, 0, 0);
    mem[1] = 32'hAAAA5555;
    do_store(32'h06, 2'd1, 32'h0000_BEEF, 3, 0);
    do_store(32'h05, 2'd1, 32'h1234_5678, 0, 0);
    do_store(32'h02, 2'd2, 32'h1234_5678, 0, 0);
    do_store(32'h08, 2'd3, 32'h1234_5678, 0, 0);
    do_store(32'h02, 2'd0, 32'h0000_007E, 0, 0);
    do_store(32'h1E, 2'd1, 32'hCAFE_F00D, 1, 2);

    // Reset while a sub-word store is in flight
    req_valid = 1'b1; req_addr = 32'h5; req_size = 2'd0; req_wdata = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_busy", mem_rd | mem_wr, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rd", mem_rd, 0);
    chk("mid_wr", mem_wr, 0);
    chk("mid_resp", resp_valid, 0);
    @(posedge clk); #1;
    chk("mid_resp2", resp_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_ready", req_ready, 1);
    chk("post_resp", resp_valid, 0);
    do_store(32'h24, 2'd2, 32'h0BAD_CAFE, 0, 1);

    // Randomized traffic against the reference memory image
    for (int i = 0; i < 80; i++)
      do_store(32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 2), $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load-path sign/zero extenders.
- Takes a 32-bit register value plus a byte address and store size (SB/SH/SW), narrows it to the addressed byte or halfword lane, and writes it into word-organised data memory.
- Sub-word stores use a read-modify-write sequence.
- Sits between the CPU's memory stage and the data-memory port; the CPU stalls while req_ready is low.

Parameters:
- ADDR_W, 32, width of the byte address on the request and memory ports.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept a request
- req_addr  in  ADDR_W  byte address of the store
- req_wdata  in  32  register data; only the low byte or low half is used for SB/SH
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: misaligned or reserved-size request
- mem_addr  out  ADDR_W  word address; bits [1:0] always 0
- mem_rd  out  1  read strobe, held until mem_rvalid
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid
- mem_wr  out  1  write strobe, held until mem_wack
- mem_wdata  out  32  merged write word
- mem_wack  in  1  write accepted

Behaviour:
- Reset (asynchronous, effective immediately):
  - state IDLE.
  - req_ready=1.
  - resp_valid, resp_err, mem_rd, mem_wr = 0.
  - mem_addr and mem_wdata = 0.
  - Internal address/data/size latches = 0.
- Handshake:
  - Request accepted on the edge where req_valid && req_ready.
  - addr, wdata and size are latched at acceptance.
  - req_ready=1 only in IDLE; the request inputs are ignored in every other state.
  - No response backpressure: resp_valid pulses for exactly one cycle, in state RESP.
- Error check at acceptance:
  - Error cases: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00.
  - Error path: go directly to RESP with resp_err=1. No memory access.
- States:
  - IDLE: accept. Word store -> WRITE. Byte/half store -> READ. Error -> RESP.
  - READ: mem_rd=1, mem_addr={addr[ADDR_W-1:2],2'b00}. When mem_rvalid: latch the merged word, then -> WRITE.
  - WRITE: mem_wr=1, mem_wdata=merged word (full req_wdata for SW). When mem_wack: -> RESP.
  - RESP: resp_valid=1, resp_err as latched -> IDLE. req_ready returns to 1 in the following cycle.
- Merge (little-endian):
  - Byte: lane k=addr[1:0] replaces bits [8k+7:8k] with wdata[7:0]; other bits come from mem_rdata.
  - Half: lane addr[1] replaces bits [16*addr[1]+15:16*addr[1]] with wdata[15:0].
  - No sign/zero extension is involved; wdata upper bits are discarded.
- Latency (zero-wait memory, acceptance at edge T):
  - SW: WRITE in cycle T+1, resp_valid in T+2.
  - SB/SH: READ in T+1, WRITE in T+2, resp_valid in T+3.
  - Error: resp_valid in T+1.
  - Each memory wait cycle adds one cycle.
- mem_rvalid outside READ and mem_wack outside WRITE are ignored.
- If mem_rvalid and mem_wack are both high in READ, only mem_rvalid is acted on.
- Reset mid-operation: strobes drop asynchronously and a partially completed RMW is abandoned. The memory word keeps whatever the memory has committed. No resp_valid is issued.
- mem_addr and mem_wdata hold their last value in IDLE and RESP.
- Back-to-back requests: the next request is accepted one cycle after RESP. No overlap.

Optional Feature:
- Macro: SMU_BYTE_STROBE_EN.
- When defined:
  - Adds output mem_be[3:0] (byte write enables).
  - Byte and half stores skip READ: IDLE -> WRITE directly, with the data replicated to all lanes ({4{wdata[7:0]}} or {2{wdata[15:0]}}).
  - mem_be is a one-hot byte mask or a 2-bit half mask; mem_be=1111 for SW.
  - mem_be=0000 outside WRITE.
  - All stores then take 2 cycles to resp_valid at zero wait.
- When undefined:
  - No mem_be port.
  - Read-modify-write as described above.

Test Plan:
- SW: addr 0x0000_0010, wdata 0xDEADBEEF, zero-wait memory -> mem_wr in T+1 with mem_addr 0x10 and mem_wdata 0xDEADBEEF; resp_valid=1, resp_err=0 in T+2; no mem_rd at any time.
- SB: addr 0x0000_0013, wdata 0xFFFF_FFA5, memory word 0x11223344 -> mem_rd in T+1; mem_wdata 0xA5223344 in T+2; resp_valid in T+3.
- SH: addr 0x0000_0006, wdata 0x0000_BEEF, memory word 0xAAAA5555 with mem_rvalid delayed 3 cycles -> mem_rd held for 3 cycles; mem_wdata 0xBEEF5555; req_ready stays 0 throughout.
- Misaligned SH at addr 0x5, SW at addr 0x2, and size=11 -> each gives resp_valid with resp_err=1 in T+1; mem_rd and mem_wr never asserted.
- rst_n pulled low during READ of an SB -> mem_rd drops in the same cycle; no mem_wr and no resp_valid; after release req_ready=1 and a new SW completes normally.
- With SMU_BYTE_STROBE_EN: SB addr 0x2, wdata 0x7E -> WRITE in T+1 with mem_be=0100 and mem_wdata 0x7E7E7E7E; resp_valid in T+2; no read issued.
